// File: rtl/mra_l1_responder.sv
// L1 request responder: queues L1 requests and serves them one at a time against a line-wide memory.
// Latency: request accepted at edge T -> mem_en in cycle T+1 -> rsp_valid in cycle T+3 (minimum).
// Backpressure: req_ready = FIFO not full; rsp_ready low parks the FSM in RESP while the FIFO keeps filling.
//
// Ports:
//   clk, reset                  rising-edge clock, synchronous active-high reset
//   req_valid/req_ready         request handshake; req_write/addr/wdata/tag carry the request
//   mem_en/mem_we/mem_addr/     one-cycle memory strobe, write enable, line index, write data
//   mem_wdata, mem_rdata        (mem_rdata is valid the cycle after mem_en)
//   rsp_valid/rsp_ready         response handshake; rsp_tag/write/err/rdata carry the response
module mra_l1_responder #(
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 512,
   parameter int TAG_WIDTH  = 8,
   parameter int DEPTH      = 4
) (
   input  logic                                        clk,
   input  logic                                        reset,
   input  logic                                        req_valid,
   output logic                                        req_ready,
   input  logic                                        req_write,
   input  logic [ADDR_WIDTH-1:0]                       req_addr,
   input  logic [DATA_WIDTH-1:0]                       req_wdata,
   input  logic [TAG_WIDTH-1:0]                        req_tag,
   output logic                                        mem_en,
   output logic                                        mem_we,
   output logic [ADDR_WIDTH-$clog2(DATA_WIDTH/8)-1:0]  mem_addr,
   output logic [DATA_WIDTH-1:0]                       mem_wdata,
   input  logic [DATA_WIDTH-1:0]                       mem_rdata,
   output logic                                        rsp_valid,
   input  logic                                        rsp_ready,
   output logic [TAG_WIDTH-1:0]                        rsp_tag,
   output logic                                        rsp_write,
   output logic                                        rsp_err,
   output logic [DATA_WIDTH-1:0]                       rsp_rdata
);

   localparam int              OFF_W    = $clog2(DATA_WIDTH/8);
   localparam int              PTR_W    = $clog2(DEPTH);
   localparam logic [PTR_W:0]  FULL_CNT = (PTR_W+1)'(DEPTH);

   typedef struct packed {
      logic                  write;
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] wdata;
      logic [TAG_WIDTH-1:0]  tag;
   } req_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   // ---------------------------------------------------------------
   // Request FIFO
   // ---------------------------------------------------------------
   req_t             fifo_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [PTR_W:0]   count_q, count_d;
   req_t             req_in, head;
   logic             push, pop, fifo_nempty;

   state_t           state_q;

   assign req_in      = {req_write, req_addr, req_wdata, req_tag};
   assign head        = fifo_q[rd_ptr_q];
   assign req_ready   = (count_q != FULL_CNT);
   assign fifo_nempty = (count_q != '0);
   assign push        = req_valid && req_ready;

   // The FSM takes the head either from IDLE or directly after a response
   // handshake, so back-to-back requests never pass through IDLE.
   assign pop = fifo_nempty &&
                ((state_q == ST_IDLE) || ((state_q == ST_RESP) && rsp_ready));

   always_comb begin
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + (PTR_W+1)'(1);
      end else if (!push && pop) begin
         count_d = count_q - (PTR_W+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q <= count_d;
      end
   end

   // Storage needs no reset: entries are only read below the count.
   always_ff @(posedge clk) begin
      if (push) fifo_q[wr_ptr_q] <= req_in;
   end

   // ---------------------------------------------------------------
   // Access FSM with registered outputs
   // ---------------------------------------------------------------
   req_t                  hold_q;
   logic                  mem_en_q, mem_we_q;
   logic                  rsp_valid_q, rsp_write_q, rsp_err_q;
   logic [TAG_WIDTH-1:0]  rsp_tag_q;
   logic [DATA_WIDTH-1:0] rsp_rdata_q;
   logic                  head_mis, hold_mis;

   assign head_mis = |head.addr[OFF_W-1:0];
   assign hold_mis = |hold_q.addr[OFF_W-1:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         hold_q      <= '0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_write_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_tag_q   <= '0;
         rsp_rdata_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: state_q <= ST_IDLE;
            ST_ISSUE: begin
               mem_en_q <= 1'b0;
               mem_we_q <= 1'b0;
               state_q  <= ST_WAIT;
            end
            ST_WAIT: begin
               // mem_rdata belongs to the access strobed last cycle.
               rsp_valid_q <= 1'b1;
               rsp_tag_q   <= hold_q.tag;
               rsp_write_q <= hold_q.write;
               rsp_err_q   <= hold_mis;
               rsp_rdata_q <= (!hold_q.write && !hold_mis) ? mem_rdata : '0;
               state_q     <= ST_RESP;
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase

         // Taking a new head overrides the IDLE/RESP next state above.
         if (pop) begin
            state_q  <= ST_ISSUE;
            hold_q   <= head;
            mem_en_q <= !head_mis;
            mem_we_q <= head.write && !head_mis;
         end
      end
   end

   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = hold_q.addr[ADDR_WIDTH-1:OFF_W];
   assign mem_wdata = hold_q.wdata;
   assign rsp_valid = rsp_valid_q;
   assign rsp_tag   = rsp_tag_q;
   assign rsp_write = rsp_write_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_mra_l1_responder.sv
module tb_mra_l1_responder;

   localparam int AW = 64;
   localparam int DW = 512;
   localparam int TW = 8;
   localparam int LW = AW - 6;

   logic          clk;
   logic          reset;
   logic          req_valid, req_ready, req_write;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic [TW-1:0] req_tag;
   logic          mem_en, mem_we;
   logic [LW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;
   logic          rsp_valid, rsp_ready, rsp_write, rsp_err;
   logic [TW-1:0] rsp_tag;
   logic [DW-1:0] rsp_rdata;

   int checks = 0;
   int errors = 0;

   mra_l1_responder #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW), .DEPTH(4)
   ) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_tag(req_tag),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tag(rsp_tag),
      .rsp_write(rsp_write), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Line L holds a distinct pattern; line 1 is all 0xA5.
   function automatic logic [DW-1:0] line_data(input logic [LW-1:0] l);
      logic [31:0] w;
      w = l[31:0] ^ 32'hA5A5_A5A4;
      return {16{w}};
   endfunction

   // Memory answers a read one cycle after the strobe, garbage otherwise.
   always @(posedge clk) begin
      mem_rdata <= (mem_en && !mem_we) ? line_data(mem_addr) : {16{32'hDEAD_BEEF}};
   end

   task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [TW-1:0] t);
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      req_tag   = t;
      req_valid = 1'b1;
   endtask

   logic [TW-1:0] tags [8];
   logic [DW-1:0] dats [8];
   int            got;
   logic          sent;

   // Collect up to n responses with rsp_ready high; a pending request is
   // dropped from req_valid once it is accepted.
   task automatic collect(input int n);
      logic acc_now;
      got  = 0;
      sent = 1'b0;
      for (int cyc = 0; cyc < 100 && got < n; cyc++) begin
         acc_now = req_valid && req_ready;
         if (rsp_valid) begin
            tags[got] = rsp_tag;
            dats[got] = rsp_rdata;
            got++;
         end
         tick;
         if (acc_now) begin
            req_valid = 1'b0;
            sent      = 1'b1;
         end
      end
   endtask

   initial begin
      int   c, nv, acc, w;
      int   vc [3];
      logic saw_rsp, saw_mem;

      reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
      req_wdata = '0; req_tag = '0; rsp_ready = 1'b1;
      tick; tick;
      reset = 1'b0;

      // Reset state
      chk("rst_req_ready", DW'(req_ready), DW'(1'b1));
      chk("rst_mem_en",    DW'(mem_en),    DW'(1'b0));
      chk("rst_mem_we",    DW'(mem_we),    DW'(1'b0));
      chk("rst_rsp_valid", DW'(rsp_valid), DW'(1'b0));
      chk("rst_rsp_err",   DW'(rsp_err),   DW'(1'b0));
      chk("rst_rsp_tag",   DW'(rsp_tag),   DW'(0));
      chk("rst_rsp_rdata", rsp_rdata,      DW'(0));
      tick;

      // Single aligned read
      drive(1'b0, 64'h40, '0, 8'h05);
      chk("rd_ready", DW'(req_ready), DW'(1'b1));
      tick; req_valid = 1'b0;
      chk("rd_T_mem_en", DW'(mem_en), DW'(1'b0));
      tick;
      chk("rd_T1_mem_en",   DW'(mem_en),   DW'(1'b1));
      chk("rd_T1_mem_we",   DW'(mem_we),   DW'(1'b0));
      chk("rd_T1_mem_addr", DW'(mem_addr), DW'(1));
      tick;
      chk("rd_T2_mem_en",    DW'(mem_en),    DW'(1'b0));
      chk("rd_T2_rsp_valid", DW'(rsp_valid), DW'(1'b0));
      tick;
      chk("rd_T3_rsp_valid", DW'(rsp_valid), DW'(1'b1));
      chk("rd_rsp_tag",      DW'(rsp_tag),   DW'(8'h05));
      chk("rd_rsp_rdata",    rsp_rdata,      {64{8'hA5}});
      chk("rd_rsp_err",      DW'(rsp_err),   DW'(1'b0));
      chk("rd_rsp_write",    DW'(rsp_write), DW'(1'b0));
      tick;
      chk("rd_T4_rsp_valid", DW'(rsp_valid), DW'(1'b0));

      // Aligned write
      drive(1'b1, 64'h80, DW'(16'h1234), 8'h11);
      tick; req_valid = 1'b0;
      tick;
      chk("wr_mem_en",    DW'(mem_en),   DW'(1'b1));
      chk("wr_mem_we",    DW'(mem_we),   DW'(1'b1));
      chk("wr_mem_addr",  DW'(mem_addr), DW'(2));
      chk("wr_mem_wdata", mem_wdata,     DW'(16'h1234));
      tick; tick;
      chk("wr_rsp_valid", DW'(rsp_valid), DW'(1'b1));
      chk("wr_rsp_write", DW'(rsp_write), DW'(1'b1));
      chk("wr_rsp_rdata", rsp_rdata,      DW'(0));
      chk("wr_rsp_tag",   DW'(rsp_tag),   DW'(8'h11));
      chk("wr_rsp_err",   DW'(rsp_err),   DW'(1'b0));
      tick;

      // Misaligned read
      drive(1'b0, 64'h44, '0, 8'h22);
      tick; req_valid = 1'b0;
      tick;
      chk("mis_mem_en", DW'(mem_en), DW'(1'b0));
      tick; tick;
      chk("mis_rsp_valid", DW'(rsp_valid), DW'(1'b1));
      chk("mis_rsp_err",   DW'(rsp_err),   DW'(1'b1));
      chk("mis_rsp_rdata", rsp_rdata,      DW'(0));
      chk("mis_rsp_tag",   DW'(rsp_tag),   DW'(8'h22));
      tick;

      // Throughput: three back-to-back writes -> responses in cycles T+3, T+6, T+9
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 64'h100 + AW'(i * 64), DW'(i), TW'(8'h50 + i));
         tick;
      end
      req_valid = 1'b0;
      c = 2; nv = 0;
      for (int k = 0; k < 3; k++) vc[k] = -1;
      for (int k = 0; k < 12; k++) begin
         tick; c++;
         if (rsp_valid) begin
            if (nv < 3) vc[nv] = c;
            nv++;
         end
      end
      chk("tp_count", DW'(nv),    DW'(3));
      chk("tp_rsp0",  DW'(vc[0]), DW'(3));
      chk("tp_rsp1",  DW'(vc[1]), DW'(6));
      chk("tp_rsp2",  DW'(vc[2]), DW'(9));

      // Backpressure: rsp_ready low, six requests -> five accepted
      rsp_ready = 1'b0;
      acc = 0;
      for (int i = 0; i < 6; i++) begin
         drive(1'b0, 64'h200 + AW'(i * 64), '0, TW'(8'h30 + i));
         w = 0;
         while (!req_ready && w < 10) begin tick; w++; end
         if (req_ready) begin tick; acc++; end
      end
      chk("bp_accepted",  DW'(acc),       DW'(5));
      chk("bp_req_ready", DW'(req_ready), DW'(1'b0));
      chk("bp_held_vld",  DW'(rsp_valid), DW'(1'b1));
      chk("bp_held_tag",  DW'(rsp_tag),   DW'(8'h30));
      rsp_ready = 1'b1;
      collect(6);
      chk("bp_got",   DW'(got),  DW'(6));
      chk("bp_sent6", DW'(sent), DW'(1'b1));
      for (int j = 0; j < 6; j++) begin
         chk($sformatf("bp_tag%0d", j),   DW'(tags[j]), DW'(8'h30 + j));
         chk($sformatf("bp_rdata%0d", j), dats[j],      line_data(LW'(8 + j)));
      end
      tick;

      // Push and pop on the same edge with three queued; pointers wrap
      rsp_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 64'h400 + AW'(i * 64), '0, TW'(8'h40 + i));
         tick;
      end
      chk("wrap_A_vld",   DW'(rsp_valid), DW'(1'b1));
      chk("wrap_A_tag",   DW'(rsp_tag),   DW'(8'h40));
      chk("wrap_ready3",  DW'(req_ready), DW'(1'b1));
      drive(1'b0, 64'h500, '0, 8'h44);
      rsp_ready = 1'b1;
      tick;
      chk("wrap_same_edge_ready", DW'(req_ready), DW'(1'b1));
      chk("wrap_A_done",          DW'(rsp_valid), DW'(1'b0));
      rsp_ready = 1'b0;
      drive(1'b0, 64'h540, '0, 8'h45);
      tick; req_valid = 1'b0;
      chk("wrap_full", DW'(req_ready), DW'(1'b0));
      rsp_ready = 1'b1;
      collect(5);
      chk("wrap_got", DW'(got), DW'(5));
      for (int j = 0; j < 5; j++) begin
         chk($sformatf("wrap_tag%0d", j),   DW'(tags[j]), DW'(8'h41 + j));
         chk($sformatf("wrap_rdata%0d", j), dats[j],      line_data(LW'(17 + j)));
      end
      tick;

      // Reset while in WAIT with two requests queued
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 64'h600 + AW'(i * 64), '0, TW'(8'h60 + i));
         tick;
      end
      req_valid = 1'b0;
      reset = 1'b1;
      tick;
      reset = 1'b0;
      chk("mid_rst_rsp_valid", DW'(rsp_valid), DW'(1'b0));
      chk("mid_rst_mem_en",    DW'(mem_en),    DW'(1'b0));
      chk("mid_rst_req_ready", DW'(req_ready), DW'(1'b1));
      saw_rsp = 1'b0; saw_mem = 1'b0;
      for (int k = 0; k < 12; k++) begin
         tick;
         if (rsp_valid) saw_rsp = 1'b1;
         if (mem_en)    saw_mem = 1'b1;
      end
      chk("post_rst_no_rsp", DW'(saw_rsp), DW'(1'b0));
      chk("post_rst_no_mem", DW'(saw_mem), DW'(1'b0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
